// File: rtl/axi_pkg.sv
// Shared AXI3 definitions for the axi_mem slave model.
// Contents: burst and response encodings, FSM state types, and the
// per-beat address-advance helper used by both the read and write paths.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_EXOKAY = 2'd1;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

  // Address of the beat following 'addr'. INCR aligns to the transfer size
  // so an unaligned first beat is followed by aligned beats. The reserved
  // burst encoding falls into the INCR branch.
  function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                            input logic [2:0]  size,
                                            input logic [3:0]  len,
                                            input logic [1:0]  burst);
    logic [31:0] step_s;
    logic [31:0] bound_s;
    logic [31:0] result_s;
    step_s  = 32'd1 << size;
    bound_s = step_s * ({28'd0, len} + 32'd1);
    case (burst)
      BURST_FIXED: result_s = addr;
      BURST_WRAP:  result_s = (addr & ~(bound_s - 32'd1)) |
                              ((addr + step_s) & (bound_s - 32'd1));
      BURST_INCR:  result_s = (addr & ~(step_s - 32'd1)) + step_s;
      default:     result_s = (addr & ~(step_s - 32'd1)) + step_s;
    endcase
    return result_s;
  endfunction

endpackage

// File: rtl/axi_mem_ram.sv
// Byte-lane RAM backing axi_mem.
// Ports: ACLK clock; wr_en/wr_addr/wr_data/wr_strb synchronous write port
// (lane i goes to byte i of the bus word containing wr_addr); rd_addr/rd_data
// asynchronous read of the whole bus word containing rd_addr.
// Contents are not reset.
module axi_mem_ram
  import axi_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int STRB_W   = DATA_W / 8,
  parameter int ADDR_LEN = 12
) (
  input  logic                ACLK,
  input  logic                wr_en,
  input  logic [ADDR_LEN-1:0] wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [STRB_W-1:0]   wr_strb,
  input  logic [ADDR_LEN-1:0] rd_addr,
  output logic [DATA_W-1:0]   rd_data
);

  localparam int LANE_BITS = $clog2(STRB_W);
  localparam int DEPTH     = 1 << ADDR_LEN;

  logic [7:0] mem_r [DEPTH];

  // Strobed byte writes into the bus-aligned word.
  always_ff @(posedge ACLK) begin
    if (wr_en) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wr_strb[i]) begin
          mem_r[{wr_addr[ADDR_LEN-1:LANE_BITS], LANE_BITS'(i)}] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  // Whole-word combinational read of the bus-aligned word.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < STRB_W; i++) begin
      rd_data[8*i +: 8] = mem_r[{rd_addr[ADDR_LEN-1:LANE_BITS], LANE_BITS'(i)}];
    end
  end

endmodule

// File: rtl/axi_mem.sv
// AXI3 slave memory model of 1<<ADDR_LENGTH bytes.
// Ports: ACLK/ARESETn clock and async active-low reset; AW*/W*/B* write
// channels; AR*/R* read channels; CSYSREQ/CSYSACK/CACTIVE low-power handshake.
// Read and write paths are independent, one outstanding transaction each.
// All responses are OKAY; lock is accepted and ignored; WID is ignored.
module axi_mem
  import axi_pkg::*;
#(
  parameter int AXI_WIDTH_CID = 0,
  parameter int AXI_WIDTH_ID  = 4,
  parameter int AXI_WIDTH_AD  = 32,
  parameter int AXI_WIDTH_DA  = 32,
  parameter int AXI_WIDTH_DS  = AXI_WIDTH_DA / 8,
  parameter int ADDR_LENGTH   = 12
) (
  input  logic                                  ACLK,
  input  logic                                  ARESETn,
  input  logic [AXI_WIDTH_CID+AXI_WIDTH_ID-1:0] AWID,
  input  logic [AXI_WIDTH_AD-1:0]               AWADDR,
  input  logic [3:0]                            AWLEN,
  input  logic [1:0]                            AWLOCK,
  input  logic [2:0]                            AWSIZE,
  input  logic [1:0]                            AWBURST,
  input  logic                                  AWVALID,
  output logic                                  AWREADY,
  input  logic [AXI_WIDTH_CID+AXI_WIDTH_ID-1:0] WID,
  input  logic [AXI_WIDTH_DA-1:0]               WDATA,
  input  logic [AXI_WIDTH_DS-1:0]               WSTRB,
  input  logic                                  WLAST,
  input  logic                                  WVALID,
  output logic                                  WREADY,
  output logic [AXI_WIDTH_CID+AXI_WIDTH_ID-1:0] BID,
  output logic [1:0]                            BRESP,
  output logic                                  BVALID,
  input  logic                                  BREADY,
  input  logic [AXI_WIDTH_CID+AXI_WIDTH_ID-1:0] ARID,
  input  logic [AXI_WIDTH_AD-1:0]               ARADDR,
  input  logic [3:0]                            ARLEN,
  input  logic [1:0]                            ARLOCK,
  input  logic [2:0]                            ARSIZE,
  input  logic [1:0]                            ARBURST,
  input  logic                                  ARVALID,
  output logic                                  ARREADY,
  output logic [AXI_WIDTH_CID+AXI_WIDTH_ID-1:0] RID,
  output logic [AXI_WIDTH_DA-1:0]               RDATA,
  output logic [1:0]                            RRESP,
  output logic                                  RLAST,
  output logic                                  RVALID,
  input  logic                                  RREADY,
  input  logic                                  CSYSREQ,
  output logic                                  CSYSACK,
  output logic                                  CACTIVE
);

  localparam int SID = AXI_WIDTH_CID + AXI_WIDTH_ID;
  localparam int AL  = ADDR_LENGTH;

  // ---------------- write path ----------------
  w_state_e        w_state_r, w_state_s;
  logic            awready_r, awready_s;
  logic            wready_r, wready_s;
  logic            bvalid_r, bvalid_s;
  logic [SID-1:0]  bid_r;
  logic [AL-1:0]   waddr_r;
  logic [3:0]      wlen_r, wcnt_r;
  logic [2:0]      wsize_r;
  logic [1:0]      wburst_r;
  logic [31:0]     wnext_s;
  logic            aw_hs_s, w_hs_s, b_hs_s, w_last_beat_s;

  assign aw_hs_s       = AWVALID & awready_r;
  assign w_hs_s        = WVALID & wready_r;
  assign b_hs_s        = bvalid_r & BREADY;
  // WLAST and the beat count both end the burst; whichever comes first wins.
  assign w_last_beat_s = WLAST | (wcnt_r == wlen_r);
  assign wnext_s       = next_addr({{(32-AL){1'b0}}, waddr_r}, wsize_r, wlen_r, wburst_r);

  // Write FSM next state and next registered handshake outputs.
  always_comb begin
    w_state_s = w_state_r;
    awready_s = awready_r;
    wready_s  = wready_r;
    bvalid_s  = bvalid_r;
    case (w_state_r)
      W_IDLE: begin
        if (aw_hs_s) begin
          w_state_s = W_DATA;
          awready_s = 1'b0;
          wready_s  = 1'b1;
        end else begin
          awready_s = 1'b1;
        end
      end
      W_DATA: begin
        if (w_hs_s && w_last_beat_s) begin
          w_state_s = W_RESP;
          wready_s  = 1'b0;
          bvalid_s  = 1'b1;
        end else begin
          wready_s  = 1'b1;
        end
      end
      W_RESP: begin
        if (b_hs_s) begin
          w_state_s = W_IDLE;
          bvalid_s  = 1'b0;
          awready_s = 1'b1;
        end else begin
          bvalid_s  = 1'b1;
        end
      end
      default: begin
        w_state_s = W_IDLE;
        awready_s = 1'b0;
        wready_s  = 1'b0;
        bvalid_s  = 1'b0;
      end
    endcase
  end

  // Write FSM state and handshake output registers.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state_r <= W_IDLE;
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
    end else begin
      w_state_r <= w_state_s;
      awready_r <= awready_s;
      wready_r  <= wready_s;
      bvalid_r  <= bvalid_s;
    end
  end

  // Write burst context: latched on AW, address/count advanced per W beat.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      bid_r    <= '0;
      waddr_r  <= '0;
      wlen_r   <= 4'd0;
      wcnt_r   <= 4'd0;
      wsize_r  <= 3'd0;
      wburst_r <= 2'd0;
    end else if (aw_hs_s) begin
      bid_r    <= AWID;
      waddr_r  <= AWADDR[AL-1:0];
      wlen_r   <= AWLEN;
      wcnt_r   <= 4'd0;
      wsize_r  <= AWSIZE;
      wburst_r <= AWBURST;
    end else if (w_hs_s) begin
      waddr_r  <= wnext_s[AL-1:0];
      wcnt_r   <= wcnt_r + 4'd1;
    end
  end

  // ---------------- read path ----------------
  r_state_e              r_state_r, r_state_s;
  logic                  arready_r, arready_s;
  logic                  rvalid_r, rvalid_s;
  logic [SID-1:0]        rid_r;
  logic [AXI_WIDTH_DA-1:0] rdata_r, ram_rdata_s;
  logic                  rlast_r;
  logic [AL-1:0]         raddr_r, rd_addr_s;
  logic [3:0]            rlen_r, rcnt_r, rd_len_s;
  logic [2:0]            rsize_r, rd_size_s;
  logic [1:0]            rburst_r, rd_burst_s;
  logic [31:0]           rnext_s;
  logic                  ar_hs_s, r_hs_s;

  assign ar_hs_s = ARVALID & arready_r;
  assign r_hs_s  = rvalid_r & RREADY;

  // RAM read address: the AR address while idle, else the next beat's
  // address, so each registered RDATA is loaded at the preceding handshake.
  always_comb begin
    if (r_state_r == R_IDLE) begin
      rd_addr_s  = ARADDR[AL-1:0];
      rd_len_s   = ARLEN;
      rd_size_s  = ARSIZE;
      rd_burst_s = ARBURST;
    end else begin
      rd_addr_s  = raddr_r;
      rd_len_s   = rlen_r;
      rd_size_s  = rsize_r;
      rd_burst_s = rburst_r;
    end
  end

  assign rnext_s = next_addr({{(32-AL){1'b0}}, rd_addr_s}, rd_size_s, rd_len_s, rd_burst_s);

  // Read FSM next state and next registered handshake outputs.
  always_comb begin
    r_state_s = r_state_r;
    arready_s = arready_r;
    rvalid_s  = rvalid_r;
    case (r_state_r)
      R_IDLE: begin
        if (ar_hs_s) begin
          r_state_s = R_DATA;
          arready_s = 1'b0;
          rvalid_s  = 1'b1;
        end else begin
          arready_s = 1'b1;
        end
      end
      R_DATA: begin
        if (r_hs_s && rlast_r) begin
          r_state_s = R_IDLE;
          rvalid_s  = 1'b0;
          arready_s = 1'b1;
        end else begin
          rvalid_s  = 1'b1;
        end
      end
      default: begin
        r_state_s = R_IDLE;
        arready_s = 1'b0;
        rvalid_s  = 1'b0;
      end
    endcase
  end

  // Read FSM state and handshake output registers.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state_r <= R_IDLE;
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
    end else begin
      r_state_r <= r_state_s;
      arready_r <= arready_s;
      rvalid_r  <= rvalid_s;
    end
  end

  // Read burst context and registered R payload; payload holds while stalled.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rid_r    <= '0;
      rdata_r  <= '0;
      rlast_r  <= 1'b0;
      raddr_r  <= '0;
      rlen_r   <= 4'd0;
      rcnt_r   <= 4'd0;
      rsize_r  <= 3'd0;
      rburst_r <= 2'd0;
    end else if (ar_hs_s) begin
      rid_r    <= ARID;
      rdata_r  <= ram_rdata_s;
      rlast_r  <= (ARLEN == 4'd0);
      raddr_r  <= rnext_s[AL-1:0];
      rlen_r   <= ARLEN;
      rcnt_r   <= 4'd0;
      rsize_r  <= ARSIZE;
      rburst_r <= ARBURST;
    end else if (r_hs_s && !rlast_r) begin
      rdata_r  <= ram_rdata_s;
      rlast_r  <= ((rcnt_r + 4'd1) == rlen_r);
      raddr_r  <= rnext_s[AL-1:0];
      rcnt_r   <= rcnt_r + 4'd1;
    end else if (r_hs_s) begin
      rlast_r  <= 1'b0;
    end
  end

  axi_mem_ram #(
    .DATA_W   (AXI_WIDTH_DA),
    .STRB_W   (AXI_WIDTH_DS),
    .ADDR_LEN (AL)
  ) u_ram (
    .ACLK    (ACLK),
    .wr_en   (w_hs_s),
    .wr_addr (waddr_r),
    .wr_data (WDATA),
    .wr_strb (WSTRB),
    .rd_addr (rd_addr_s),
    .rd_data (ram_rdata_s)
  );

  // ---------------- low-power interface ----------------
  logic csysack_r, cactive_r;

  // CACTIVE comes up on the first clock out of reset; CSYSACK follows CSYSREQ.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      csysack_r <= 1'b0;
      cactive_r <= 1'b0;
    end else begin
      csysack_r <= CSYSREQ;
      cactive_r <= 1'b1;
    end
  end

  // Inputs the model deliberately ignores (lock, WID, aliased address bits).
  logic unused_s;
  assign unused_s = ^{WID, AWLOCK, ARLOCK,
                      AWADDR[AXI_WIDTH_AD-1:AL], ARADDR[AXI_WIDTH_AD-1:AL]};

  assign AWREADY = awready_r;
  assign WREADY  = wready_r;
  assign BVALID  = bvalid_r;
  assign BID     = bid_r;
  assign BRESP   = RESP_OKAY;
  assign ARREADY = arready_r;
  assign RVALID  = rvalid_r;
  assign RID     = rid_r;
  assign RDATA   = rdata_r;
  assign RRESP   = RESP_OKAY;
  assign RLAST   = rlast_r;
  assign CSYSACK = csysack_r;
  assign CACTIVE = cactive_r;

endmodule

// File: tb/tb_axi_mem.sv
// Directed self-checking bench for axi_mem. Inputs change and outputs are
// sampled on the falling edge; every expected value is written out by hand.
module tb_axi_mem;
  import axi_pkg::*;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [3:0]  AWID, WID, BID, ARID, RID;
  logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
  logic [3:0]  AWLEN, ARLEN, WSTRB;
  logic [1:0]  AWLOCK, ARLOCK, AWBURST, ARBURST, BRESP, RRESP;
  logic [2:0]  AWSIZE, ARSIZE;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic        CSYSREQ, CSYSACK, CACTIVE;

  int checks   = 0;
  int failures = 0;

  always #5 ACLK = ~ACLK;

  axi_mem dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWLOCK(AWLOCK),
    .AWSIZE(AWSIZE), .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
    .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARLOCK(ARLOCK),
    .ARSIZE(ARSIZE), .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
    .RVALID(RVALID), .RREADY(RREADY),
    .CSYSREQ(CSYSREQ), .CSYSACK(CSYSACK), .CACTIVE(CACTIVE)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pick(input int b, input logic [31:0] d0, input logic [31:0] d1,
                                       input logic [31:0] d2, input logic [31:0] d3);
    case (b)
      0:       return d0;
      1:       return d1;
      2:       return d2;
      default: return d3;
    endcase
  endfunction

  // Full write transaction; BREADY is withheld for bstall cycles after BVALID.
  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [1:0] burst, input logic [3:0] strb,
                          input logic [31:0] d0, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] d3, input int bstall);
    int n;
    n = int'(len);
    AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = 3'd2; AWBURST = burst;
    AWLOCK = 2'd0; AWVALID = 1'b1;
    for (int k = 0; k < 20 && AWREADY !== 1'b1; k++) @(negedge ACLK);
    check("awready", 32'(AWREADY), 32'd1);
    @(negedge ACLK);
    AWVALID = 1'b0;
    for (int b = 0; b <= n; b++) begin
      WDATA = pick(b, d0, d1, d2, d3); WSTRB = strb; WLAST = (b == n); WVALID = 1'b1;
      for (int k = 0; k < 20 && WREADY !== 1'b1; k++) @(negedge ACLK);
      check("wready", 32'(WREADY), 32'd1);
      @(negedge ACLK);
    end
    WVALID = 1'b0; WLAST = 1'b0;
    for (int k = 0; k < 20 && BVALID !== 1'b1; k++) @(negedge ACLK);
    check("bvalid", 32'(BVALID), 32'd1);
    check("bid", 32'(BID), 32'(id));
    check("bresp", 32'(BRESP), 32'd0);
    for (int s = 0; s < bstall; s++) begin
      @(negedge ACLK);
      check("bvalid_hold", 32'(BVALID), 32'd1);
      check("bid_hold", 32'(BID), 32'(id));
    end
    BREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0;
    check("bvalid_clear", 32'(BVALID), 32'd0);
    check("awready_back", 32'(AWREADY), 32'd1);
  endtask

  // Full read transaction with RREADY held high; checks every beat.
  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [1:0] burst, input logic [31:0] e0, input logic [31:0] e1,
                         input logic [31:0] e2, input logic [31:0] e3);
    int n;
    n = int'(len);
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = 3'd2; ARBURST = burst;
    ARLOCK = 2'd0; ARVALID = 1'b1;
    for (int k = 0; k < 20 && ARREADY !== 1'b1; k++) @(negedge ACLK);
    check("arready", 32'(ARREADY), 32'd1);
    @(negedge ACLK);
    ARVALID = 1'b0;
    RREADY  = 1'b1;
    for (int b = 0; b <= n; b++) begin
      for (int k = 0; k < 20 && RVALID !== 1'b1; k++) @(negedge ACLK);
      check("rvalid", 32'(RVALID), 32'd1);
      check("rdata", RDATA, pick(b, e0, e1, e2, e3));
      check("rid", 32'(RID), 32'(id));
      check("rlast", 32'(RLAST), (b == n) ? 32'd1 : 32'd0);
      check("rresp", 32'(RRESP), 32'd0);
      @(negedge ACLK);
    end
    RREADY = 1'b0;
    check("rvalid_clear", 32'(RVALID), 32'd0);
    check("arready_back", 32'(ARREADY), 32'd1);
  endtask

  initial begin
    int          beat;
    logic        rr;
    logic [31:0] exp_a [4];

    ARESETn = 1'b0;
    AWID = 4'd0; AWADDR = 32'd0; AWLEN = 4'd0; AWLOCK = 2'd0; AWSIZE = 3'd0;
    AWBURST = 2'd0; AWVALID = 1'b0; WID = 4'd0; WDATA = 32'd0; WSTRB = 4'd0;
    WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0; ARID = 4'd0; ARADDR = 32'd0;
    ARLEN = 4'd0; ARLOCK = 2'd0; ARSIZE = 3'd0; ARBURST = 2'd0; ARVALID = 1'b0;
    RREADY = 1'b0; CSYSREQ = 1'b0;

    repeat (3) @(negedge ACLK);
    check("rst_awready", 32'(AWREADY), 32'd0);
    check("rst_wready", 32'(WREADY), 32'd0);
    check("rst_bvalid", 32'(BVALID), 32'd0);
    check("rst_arready", 32'(ARREADY), 32'd0);
    check("rst_rvalid", 32'(RVALID), 32'd0);
    check("rst_rdata", RDATA, 32'd0);
    check("rst_rlast", 32'(RLAST), 32'd0);
    check("rst_cactive", 32'(CACTIVE), 32'd0);
    check("rst_csysack", 32'(CSYSACK), 32'd0);

    ARESETn = 1'b1;
    CSYSREQ = 1'b1;
    @(negedge ACLK);
    check("cactive_up", 32'(CACTIVE), 32'd1);
    check("csysack_up", 32'(CSYSACK), 32'd1);
    check("awready_up", 32'(AWREADY), 32'd1);
    check("arready_up", 32'(ARREADY), 32'd1);

    // Single write / read.
    do_write(4'd3, 32'h010, 4'd0, BURST_INCR, 4'hF, 32'h11223344, 32'd0, 32'd0, 32'd0, 0);
    do_read(4'd5, 32'h010, 4'd0, BURST_INCR, 32'h11223344, 32'd0, 32'd0, 32'd0);

    // INCR burst of four.
    do_write(4'd1, 32'h100, 4'd3, BURST_INCR, 4'hF, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 0);
    do_read(4'd2, 32'h100, 4'd3, BURST_INCR, 32'hA0, 32'hA1, 32'hA2, 32'hA3);

    // WRAP read starting at the top of a 16-byte window.
    do_write(4'd4, 32'h100, 4'd3, BURST_INCR, 4'hF, 32'h100, 32'h104, 32'h108, 32'h10C, 0);
    do_read(4'd6, 32'h10C, 4'd3, BURST_WRAP, 32'h10C, 32'h100, 32'h104, 32'h108);

    // Partial strobe merges into existing data.
    do_write(4'd7, 32'h020, 4'd0, BURST_INCR, 4'hF, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd0, 0);
    do_write(4'd8, 32'h020, 4'd0, BURST_INCR, 4'b0010, 32'h0000AB00, 32'd0, 32'd0, 32'd0, 0);
    do_read(4'd9, 32'h020, 4'd0, BURST_INCR, 32'hFFFFABFF, 32'd0, 32'd0, 32'd0);

    // B channel held off for five cycles.
    do_write(4'hA, 32'h040, 4'd0, BURST_INCR, 4'hF, 32'hDEADBEEF, 32'd0, 32'd0, 32'd0, 5);

    // Read with RREADY toggling every cycle; payload must hold while stalled.
    exp_a[0] = 32'h100; exp_a[1] = 32'h104; exp_a[2] = 32'h108; exp_a[3] = 32'h10C;
    ARID = 4'hB; ARADDR = 32'h100; ARLEN = 4'd3; ARSIZE = 3'd2; ARBURST = BURST_INCR;
    ARVALID = 1'b1;
    for (int k = 0; k < 20 && ARREADY !== 1'b1; k++) @(negedge ACLK);
    check("stall_arready", 32'(ARREADY), 32'd1);
    @(negedge ACLK);
    ARVALID = 1'b0;
    beat = 0;
    rr   = 1'b0;
    for (int cyc = 0; cyc < 40 && beat < 4; cyc++) begin
      if (RVALID === 1'b1) begin
        check("stall_rdata", RDATA, exp_a[beat]);
        check("stall_rid", 32'(RID), 32'hB);
        check("stall_rlast", 32'(RLAST), (beat == 3) ? 32'd1 : 32'd0);
      end
      rr     = ~rr;
      RREADY = rr;
      if (RVALID === 1'b1 && rr) beat++;
      @(negedge ACLK);
    end
    RREADY = 1'b0;
    check("stall_beats", 32'(beat), 32'd4);
    check("stall_rvalid_clear", 32'(RVALID), 32'd0);

    // Address aliasing above ADDR_LENGTH bits.
    do_write(4'hC, 32'h1010, 4'd0, BURST_INCR, 4'hF, 32'h55, 32'd0, 32'd0, 32'd0, 0);
    do_read(4'hD, 32'h010, 4'd0, BURST_INCR, 32'h55, 32'd0, 32'd0, 32'd0);

    // Low-power request dropped.
    CSYSREQ = 1'b0;
    @(negedge ACLK);
    check("csysack_down", 32'(CSYSACK), 32'd0);
    check("cactive_stays", 32'(CACTIVE), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
